fetch_stage: RTL and testbench

//  Instruction fetch stage. Sits directly upstream of decode.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / drop_word_cnt performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] drop_word_cnt
`endif
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] fifo_wr, fifo_rd;
    logic [AW-1:0] pcq_wr, pcq_rd;

    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] pcq_mem   [DEPTH];

    logic        req_fire;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;
    logic [1:0]  unused_pc_bits;

    assign unused_pc_bits = redirect_pc[1:0];

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_valid = !reset && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
        push           = imem_rsp_valid && !rsp_drop;
        pop            = instr_valid && instr_ready && !redirect_valid;
    end

    assign imem_addr   = pc_q;
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? fifo_data[fifo_rd] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[fifo_rd]   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            outstanding <= '0;
            fifo_count  <= '0;
            drop_cnt    <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            // Outstanding includes requests already condemned by drop_cnt; imem still answers them.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc_q       <= {redirect_pc[31:2], 2'b00};
                drop_cnt   <= outstanding - CW'(imem_rsp_valid);
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                pcq_wr     <= '0;
                pcq_rd     <= '0;
            end else begin
                if (req_fire) begin
                    pc_q   <= pc_q + 32'd4;
                    pcq_wr <= pcq_wr + 1'b1;
                end
                if (rsp_drop)
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    fifo_wr <= fifo_wr + 1'b1;
                    pcq_rd  <= pcq_rd + 1'b1;
                end
                if (pop)
                    fifo_rd <= fifo_rd + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire)
            pcq_mem[pcq_wr] <= pc_q;
        if (push) begin
            fifo_data[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
        end
        if (!reset && push && !pop)
            assert (fifo_count != DEPTH_C);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt     <= '0;
            drop_word_cnt <= '0;
        end else begin
            if (pop)
                fetch_cnt <= fetch_cnt + 32'd1;
            // A flush discards every buffered word plus any response landing in the same cycle.
            if (redirect_valid)
                drop_word_cnt <= drop_word_cnt + 32'(fifo_count) + 32'(imem_rsp_valid);
            else if (rsp_drop)
                drop_word_cnt <= drop_word_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus hand-timed redirect sequences,
// driving an in-order imem model with programmable latency.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_word_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .drop_word_cnt  (drop_word_cnt)
`endif
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    vec_t        vecs   [18];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs for this cycle (called just after a rising edge), then move to the sampling point.
    task automatic begin_cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_req_ready = 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #4;
    endtask

    task automatic end_cycle();
        if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
        end
        if (imem_rsp_valid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_cycle(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_valid, input logic [31:0] exp_pc);
        check({tag, " req_valid"}, 32'(imem_req_valid), 32'(exp_req));
        check({tag, " imem_addr"}, imem_addr, exp_addr);
        check({tag, " instr_valid"}, 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({tag, " instr_pc"}, instr_pc, exp_pc);
            check({tag, " instr_data"}, instr_data, word_at(exp_pc));
        end
    endtask

    task automatic do_reset(input int latency);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        q_addr.delete();
        q_due.delete();
        lat = latency;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset req_valid", 32'(imem_req_valid), 32'd0);
        check("reset instr_valid", 32'(instr_valid), 32'd0);
        check("reset instr_data", instr_data, 32'd0);
        check("reset instr_pc", instr_pc, 32'd0);
        check("reset imem_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("reset fetch_cnt", fetch_cnt, 32'd0);
        check("reset drop_word_cnt", drop_word_cnt, 32'd0);
`endif
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Streaming at k=1, a 4-cycle stall, then a redirect to a misaligned PC that lands with a response.
        vecs[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, 32'h00};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0c,  1'b1, 32'h04};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h08};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h0c};
        vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b1, 32'h0c};
        vecs[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h1c,  1'b1, 32'h0c};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h1c,  1'b1, 32'h0c};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h1c,  1'b1, 32'h0c};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1c,  1'b1, 32'h10};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b1, 32'h14};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h24,  1'b1, 32'h18};
        vecs[13] = '{1'b1, 32'h203, 1'b1, 1'b0, 32'h28,  1'b1, 32'h1c};
        vecs[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200};
        vecs[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20c, 1'b1, 32'h204};

        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            begin_cycle(vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            check_cycle($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_valid, vecs[i].exp_pc);
            if (vecs[i].redir)
                check("redirect-cycle rsp present", 32'(imem_rsp_valid), 32'd1);
            end_cycle();
        end
`ifdef FETCH_PERF_CNT_EN
        check("table fetch_cnt", fetch_cnt, 32'd9);
        check("table drop_word_cnt", drop_word_cnt, 32'd3);
`endif

        // k=3: three requests in flight, redirect to 0x100 while the first response arrives.
        do_reset(3);
        for (int c = 0; c < 3; c++) begin
            begin_cycle(1'b0, 32'h0, 1'b1);
            check_cycle("k3 issue", 1'b1, 32'(4 * c), 1'b0, 32'h0);
            end_cycle();
        end
        begin_cycle(1'b1, 32'h100, 1'b1);
        check_cycle("k3 redirect", 1'b0, 32'h0c, 1'b0, 32'h0);
        end_cycle();
        for (int c = 4; c < 8; c++) begin
            begin_cycle(1'b0, 32'h0, 1'b1);
            check_cycle("k3 refill", 1'b1, 32'h100 + 32'(4 * (c - 4)), 1'b0, 32'h0);
            end_cycle();
        end
        begin_cycle(1'b0, 32'h0, 1'b1);
        check_cycle("k3 first", 1'b0, 32'h110, 1'b1, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check("k3 drop_word_cnt", drop_word_cnt, 32'd3);
        check("k3 fetch_cnt before", fetch_cnt, 32'd0);
`endif
        end_cycle();
        begin_cycle(1'b0, 32'h0, 1'b1);
        check_cycle("k3 second", 1'b1, 32'h110, 1'b1, 32'h104);
`ifdef FETCH_PERF_CNT_EN
        check("k3 fetch_cnt after", fetch_cnt, 32'd1);
`endif
        end_cycle();

        // k=2: back-to-back redirects; the second must recompute drop_cnt from current outstanding.
        do_reset(2);
        for (int c = 0; c < 2; c++) begin
            begin_cycle(1'b0, 32'h0, 1'b1);
            end_cycle();
        end
        begin_cycle(1'b1, 32'h200, 1'b1);
        check_cycle("b2b first", 1'b0, 32'h08, 1'b0, 32'h0);
        end_cycle();
        begin_cycle(1'b1, 32'h301, 1'b1);
        check_cycle("b2b second", 1'b0, 32'h200, 1'b0, 32'h0);
        end_cycle();
        for (int c = 4; c < 7; c++) begin
            begin_cycle(1'b0, 32'h0, 1'b1);
            check_cycle("b2b refill", 1'b1, 32'h300 + 32'(4 * (c - 4)), 1'b0, 32'h0);
            end_cycle();
        end
        begin_cycle(1'b0, 32'h0, 1'b1);
        check_cycle("b2b first word", 1'b1, 32'h30c, 1'b1, 32'h300);
        end_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
